// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver: prescaler, scan counter, frame shadow, LZ blanking, dead time.
// Optional hex glyphs for codes 10-15 when SEVSEG_HEX_EN is defined.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int PRESCALE         = 1000,
  parameter int DIGIT_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    blank_lz,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [6:0]              led_out,
  output logic                    frame_start
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           p;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   sel_q, onehot, lz;
  logic [6:0]              seg_q;
  logic [3:0]              cur;
  logic                    tick, zero_above;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:  return 7'b1111110;
      4'd1:  return 7'b0110000;
      4'd2:  return 7'b1101101;
      4'd3:  return 7'b1111001;
      4'd4:  return 7'b0110011;
      4'd5:  return 7'b1011011;
      4'd6:  return 7'b1011111;
      4'd7:  return 7'b1110000;
      4'd8:  return 7'b1111111;
      4'd9:  return 7'b1111011;
`ifdef SEVSEG_HEX_EN
      4'd10: return 7'b1110111;
      4'd11: return 7'b0011111;
      4'd12: return 7'b1001110;
      4'd13: return 7'b0111101;
      4'd14: return 7'b1001111;
      4'd15: return 7'b1000111;
`endif
      default: return 7'b0000000;
    endcase
  endfunction

  assign tick   = (p == P_LAST);
  assign cur    = shadow[{idx, 2'b00} +: 4];
  assign onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

  // lz[k]: every shadow digit from the top down to k is zero; digit 0 never blanks
  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (shadow[4*k +: 4] == 4'd0);
      lz[k]      = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p           <= '0;
      idx         <= '0;
      shadow      <= '0;
      frame_start <= 1'b0;
      sel_q       <= '0;
      seg_q       <= '0;
    end else begin
      p           <= tick ? '0 : p + 1'b1;
      frame_start <= tick && (idx == I_LAST);
      if (tick) begin
        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
        if (idx == I_LAST) shadow <= digits_in;
      end
      // the tick cycle doubles as the anti-ghosting gap between digits
      if (!en || tick) begin
        sel_q <= '0;
        seg_q <= '0;
      end else begin
        sel_q <= onehot;
        seg_q <= (blank_lz && lz[idx]) ? 7'b0000000 : decode(cur);
      end
    end
  end

  assign digit_sel = (DIGIT_ACTIVE_LOW != 0) ? ~sel_q : sel_q;
  assign led_out   = (SEG_ACTIVE_LOW != 0)   ? ~seg_q : seg_q;

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Multiplexed N-digit 7-segment display driver for the digital clock. Time-shares one 7-segment bus across NUM_DIGITS common-pin digits.
- Contains:
  - a refresh prescaler;
  - a digit scan counter;
  - a frame-synchronous shadow register, so the display never tears mid-frame;
  - leading-zero blanking;
  - a one-cycle anti-ghosting dead time between digits.
- Sits between the time-keeping BCD registers and the board pins, and replaces per-digit static decoders.

Parameters:
- NUM_DIGITS, 4, number of scanned digits; legal range 2..8.
- PRESCALE, 1000, clk cycles per digit slot; must be >= 2.
- DIGIT_ACTIVE_LOW, 0, 1 inverts every digit_sel bit at the output.
- SEG_ACTIVE_LOW, 0, 1 inverts every led_out bit at the output.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  display enable; 0 forces outputs inactive.
- blank_lz  input  1  1 enables leading-zero blanking.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit k in bits [4k+3:4k]; digit 0 is least significant (rightmost).
- digit_sel  output  NUM_DIGITS  one-hot digit enable; bit k drives digit k.
- led_out  output  7  segments {a,b,c,d,e,f,g}; a = bit 6, g = bit 0.
- frame_start  output  1  one-cycle pulse when the shadow register reloads.

Behaviour:
- Reset (synchronous, active-high), applied at the clk edge while reset=1:
  - prescale counter p=0, scan index idx=0, shadow=0;
  - digit_sel and led_out inactive (all 0 before polarity inversion); frame_start=0.
- Prescaler:
  - p increments every cycle and wraps PRESCALE-1 -> 0.
  - tick = (p==PRESCALE-1), combinational.
  - The prescaler and scan run regardless of en.
- Scan:
  - On each tick, idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
  - On a tick with idx==NUM_DIGITS-1, shadow <= digits_in and frame_start <= 1 for the next cycle only.
  - digits_in is sampled only at that edge; changes at any other time have no effect until the next frame.
- Output registers, updated every cycle:
  - if en==0 or tick: digit_sel=0, led_out=0 (dead time);
  - else: digit_sel = one-hot(idx), led_out = decode(shadow digit idx), blanking applied.
- Timing that follows from the output registers:
  - a tick at cycle T gives outputs off at T+1 and the new digit from T+2;
  - each digit is lit exactly PRESCALE-1 cycles per slot;
  - full frame period = NUM_DIGITS*PRESCALE cycles.
  - en falling: outputs are inactive from the next edge. en rising: outputs resume the next cycle at the current idx.
- Decode, values 0-9:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011;
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Codes 10-15 give led_out=0000000 (unless SEVSEG_HEX_EN).
- Leading-zero blanking (blank_lz=1):
  - digit k is blanked (led_out=0, digit_sel still asserted) when shadow digits NUM_DIGITS-1..k are all 0 and k != 0;
  - digit 0 is never blanked, so value 0 shows "0";
  - the computation uses shadow, not digits_in;
  - blank_lz is sampled live each cycle.
- Polarity: inversion by DIGIT_ACTIVE_LOW / SEG_ACTIVE_LOW is applied after the registers, so "inactive" means all 1s in active-low mode, including during reset.
- Reset mid-frame:
  - returns to idx=0, p=0, shadow=0;
  - the first post-reset frame therefore displays 0 until the first reload.

Optional Feature:
- Macro: SEVSEG_HEX_EN.
- When defined, codes 10-15 decode to hex glyphs: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Leading-zero blanking still treats only 0 as a zero.
- When not defined, codes 10-15 blank the digit (led_out=0).

Test Plan:
- Setup for all scenarios unless stated: NUM_DIGITS=4, PRESCALE=4, en=1, blank_lz=0.
- Reset: hold reset for 3 cycles. Outputs are 0 during reset. On the 1st cycle after release, digit_sel=0001 and led_out=1111110; at cycle 4 outputs are 0 (dead time); at cycle 5 digit_sel=0010.
- Frame load: digits_in=0x1234 before the first wrap. frame_start pulses once per 16 cycles. The next frame shows, in order, digit_sel 0001/0010/0100/1000 with led_out 0110011/1111001/1101101/0110000. Changing digits_in mid-frame does not alter the current frame.
- Blanking: blank_lz=1, digits_in=0x0007. Digits 3,2,1 have digit_sel asserted with led_out=0; digit 0 shows 1110000. With digits_in=0x0000, only digit 0 shows 1111110. With 0x0100, digit 3 is blank and digit 1 shows 1111110.
- Enable: drop en for 6 cycles mid-slot. Outputs go to 0 the next edge; frame_start cadence is unchanged; display resumes at the correct idx one cycle after en=1.
- Codes 10-15: digits_in=0xABCF. Without the macro, all digits show led_out=0. With SEVSEG_HEX_EN, the digits show 1000111, 1001110, 0011111, 1110111 (digits 0..3).
- Polarity: DIGIT_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1. During reset digit_sel=1111 and led_out=1111111; digit 0 value 8 gives digit_sel=1110, led_out=0000000.
